// File: rtl/async_oneway_receiver_if.sv
// async_oneway_receiver_if: one-way 6-bit packet link and reassembled datagram outputs
interface async_oneway_receiver_if #(
    parameter int MESSAGE_SIZE = 48
);
    logic [5:0]              packet_in;
    logic                    packet_pulse;
    logic                    transmit_ctrl;
    logic [MESSAGE_SIZE-1:0] datagram_out;
    logic                    datagram_valid;
    logic                    frame_error;
    logic                    busy;

    modport master (
        output packet_in, packet_pulse, transmit_ctrl,
        input  datagram_out, datagram_valid, frame_error, busy
    );

    modport slave (
        input  packet_in, packet_pulse, transmit_ctrl,
        output datagram_out, datagram_valid, frame_error, busy
    );
endinterface

// File: rtl/async_oneway_receiver.sv
// async_oneway_receiver: synchronises link strobes and reassembles LSB-first 6-bit packets into a datagram
module async_oneway_receiver #(
    parameter int MESSAGE_SIZE = 48,
    parameter int SYNC_STAGES  = 2
) (
    input logic                    clk_recv,
    input logic                    rst,
    async_oneway_receiver_if.slave link
);
    localparam int N  = (MESSAGE_SIZE + 5) / 6;
    localparam int W  = 6 * N;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           pkt_cnt;
    logic [W-1:0]            buffer;
    logic [SYNC_STAGES-1:0]  pulse_sync, ctrl_sync;
    logic                    pulse_prev, ctrl_prev;
    logic [MESSAGE_SIZE-1:0] datagram;
    logic                    valid, error, busy;
    logic                    pulse_rise, ctrl_rise, ctrl_fall, last_pkt;

    assign pulse_rise = pulse_sync[SYNC_STAGES-1] & ~pulse_prev;
    assign ctrl_rise  = ctrl_sync[SYNC_STAGES-1] & ~ctrl_prev;
    assign ctrl_fall  = ~ctrl_sync[SYNC_STAGES-1] & ctrl_prev;
    assign last_pkt   = pkt_cnt == CW'(N - 1);

    always_ff @(posedge clk_recv) begin
        if (rst) begin
            state      <= IDLE;
            pkt_cnt    <= '0;
            buffer     <= '0;
            pulse_sync <= '0;
            ctrl_sync  <= '0;
            pulse_prev <= 1'b0;
            ctrl_prev  <= 1'b0;
            datagram   <= '0;
            valid      <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], link.packet_pulse};
            ctrl_sync  <= {ctrl_sync[SYNC_STAGES-2:0], link.transmit_ctrl};
            pulse_prev <= pulse_sync[SYNC_STAGES-1];
            ctrl_prev  <= ctrl_sync[SYNC_STAGES-1];
            valid      <= 1'b0;
            error      <= 1'b0;
            unique case (state)
                IDLE: if (ctrl_rise) begin
                    state   <= RECV;
                    busy    <= 1'b1;
                    pkt_cnt <= '0;
                    buffer  <= '0;
                end
                RECV: if (ctrl_rise) begin
                    pkt_cnt <= '0;
                    buffer  <= '0;
                end else if (pulse_rise) begin
                    // packet_in has been stable for SYNC_STAGES cycles by the time the synced edge shows up
                    buffer  <= {link.packet_in, buffer[W-1:6]};
                    pkt_cnt <= pkt_cnt + CW'(1);
                    if (last_pkt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end else if (ctrl_fall) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    error <= 1'b1;
                end
                DONE: begin
                    datagram <= buffer[MESSAGE_SIZE-1:0];
                    valid    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign link.datagram_out   = datagram;
    assign link.datagram_valid = valid;
    assign link.frame_error    = error;
    assign link.busy           = busy;
endmodule

// File: tb/tb_async_oneway_receiver.sv
// tb_async_oneway_receiver: directed frames against the receiver with hand-computed datagrams
module tb_async_oneway_receiver;
    localparam int MS = 48;

    logic clk_recv = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_recv = ~clk_recv;

    async_oneway_receiver_if #(.MESSAGE_SIZE(MS)) link();

    async_oneway_receiver #(.MESSAGE_SIZE(MS), .SYNC_STAGES(2)) dut (
        .clk_recv(clk_recv),
        .rst(rst),
        .link(link)
    );

    int total = 0;
    int bad   = 0;
    int n_err = 0;
    time t_valid = 0;
    time t_last  = 0;
    logic [MS-1:0] got_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_recv);
    endtask

    function automatic logic [MS-1:0] pack(input logic [7:0][5:0] p);
        logic [MS-1:0] r = '0;
        for (int k = 0; k < 8; k++) r[6*k +: 6] = p[k];
        return r;
    endfunction

    function automatic logic [MS-1:0] q_at(input int i);
        return (i < got_q.size()) ? got_q[i] : '0;
    endfunction

    // Outputs change on posedge, so the falling edge gives a clean sample point
    always @(negedge clk_recv) begin
        if (link.datagram_valid) begin
            got_q.push_back(link.datagram_out);
            t_valid = $time;
        end
        if (link.frame_error) n_err++;
    end

    task automatic clear_mon();
        got_q.delete();
        n_err = 0;
    endtask

    task automatic frame(input logic [7:0][5:0] p, input int cnt, input int hi, input int lo, input bit coincide);
        link.transmit_ctrl = 1'b1;
        cyc(lo);
        for (int k = 0; k < cnt; k++) begin
            link.packet_in    = p[k];
            link.packet_pulse = 1'b1;
            t_last = $time;
            if (coincide && k == cnt - 1) link.transmit_ctrl = 1'b0;
            cyc(hi);
            link.packet_pulse = 1'b0;
            cyc(lo);
        end
        link.transmit_ctrl = 1'b0;
    endtask

    logic [7:0][5:0] p_nom, p_short, p_co, p_ones, p_a, p_b;

    initial begin
        link.packet_in     = '0;
        link.packet_pulse  = 1'b0;
        link.transmit_ctrl = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p_nom[k]   = 6'(k + 1);
            p_short[k] = 6'(6'h30 + k);
            p_co[k]    = 6'(6'h2A ^ k);
            p_ones[k]  = 6'h3F;
            p_a[k]     = 6'(6'h11 + 3 * k);
            p_b[k]     = 6'(6'h3E - 5 * k);
        end

        // reset with toggling inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_recv);
            link.transmit_ctrl = ~link.transmit_ctrl;
            link.packet_pulse  = ~link.packet_pulse;
            link.packet_in     = link.packet_in + 6'd7;
        end
        link.transmit_ctrl = 1'b0;
        link.packet_pulse  = 1'b0;
        cyc(1);
        check("rst_data", 64'(link.datagram_out), 64'h0);
        check("rst_valid", 64'(link.datagram_valid), 64'h0);
        check("rst_err", 64'(link.frame_error), 64'h0);
        check("rst_busy", 64'(link.busy), 64'h0);
        rst = 1'b0;
        clear_mon();
        cyc(4);
        check("post_rst_nvalid", 64'(got_q.size()), 64'd0);
        check("post_rst_busy", 64'(link.busy), 64'h0);

        // nominal frame, one pulse every 4 cycles
        clear_mon();
        frame(p_nom, 8, 1, 3, 1'b0);
        cyc(6);
        check("nom_nvalid", 64'(got_q.size()), 64'd1);
        check("nom_data_const", 64'(q_at(0)), 64'h2071_8510_3081);
        check("nom_data_model", 64'(link.datagram_out), 64'(pack(p_nom)));
        check("nom_latency", 64'(t_valid - t_last), 64'd40);
        check("nom_err", 64'(n_err), 64'd0);
        check("nom_busy", 64'(link.busy), 64'h0);

        // short frame: 5 packets then ctrl low
        clear_mon();
        frame(p_short, 5, 1, 3, 1'b0);
        cyc(6);
        check("short_err", 64'(n_err), 64'd1);
        check("short_nvalid", 64'(got_q.size()), 64'd0);
        check("short_hold", 64'(link.datagram_out), 64'h2071_8510_3081);
        check("short_busy", 64'(link.busy), 64'h0);

        // pulses with ctrl low are ignored
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            link.packet_in    = 6'h15;
            link.packet_pulse = 1'b1;
            cyc(1);
            link.packet_pulse = 1'b0;
            cyc(3);
            check("idle_busy", 64'(link.busy), 64'h0);
        end
        cyc(4);
        check("idle_nvalid", 64'(got_q.size()), 64'd0);
        check("idle_hold", 64'(link.datagram_out), 64'h2071_8510_3081);

        // final pulse and ctrl fall on the same synced cycle
        clear_mon();
        frame(p_co, 8, 1, 3, 1'b1);
        cyc(6);
        check("co_nvalid", 64'(got_q.size()), 64'd1);
        check("co_data", 64'(q_at(0)), 64'(pack(p_co)));
        check("co_err", 64'(n_err), 64'd0);

        // mid-frame reset after 3 packets, then a full all-ones frame
        clear_mon();
        link.transmit_ctrl = 1'b1;
        cyc(3);
        for (int k = 0; k < 3; k++) begin
            link.packet_in    = 6'h2B;
            link.packet_pulse = 1'b1;
            cyc(1);
            link.packet_pulse = 1'b0;
            cyc(3);
        end
        check("mid_busy", 64'(link.busy), 64'h1);
        rst = 1'b1;
        link.transmit_ctrl = 1'b0;
        cyc(2);
        check("mid_rst_data", 64'(link.datagram_out), 64'h0);
        rst = 1'b0;
        cyc(4);
        check("mid_rst_busy", 64'(link.busy), 64'h0);
        frame(p_ones, 8, 1, 3, 1'b0);
        cyc(6);
        check("ones_nvalid", 64'(got_q.size()), 64'd1);
        check("ones_data", 64'(link.datagram_out), 64'hFFFF_FFFF_FFFF);
        check("ones_err", 64'(n_err), 64'd0);

        // back-to-back frames at clk_recv = 2x clk_send, 3 send cycles apart
        clear_mon();
        frame(p_a, 8, 2, 2, 1'b0);
        cyc(6);
        frame(p_b, 8, 2, 2, 1'b0);
        cyc(8);
        check("b2b_nvalid", 64'(got_q.size()), 64'd2);
        check("b2b_data_a", 64'(q_at(0)), 64'(pack(p_a)));
        check("b2b_data_b", 64'(q_at(1)), 64'(pack(p_b)));
        check("b2b_err", 64'(n_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
